// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM: sequences ALU, memory, IR, PC, regfile.
// Ports: clk/rst, opcode/zero/mem_ready in; datapath controls, illegal, state_dbg, instr_retired out.
module mips_multicycle_ctrl #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic [5:0]         alu_opcode,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic               pc_write,
  output logic               ir_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               illegal,
  output logic [3:0]         state_dbg,
  output logic [COUNT_W-1:0] instr_retired
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    WB_LOAD  = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    WB_R     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    TRAP     = 4'd10
  } state_t;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;

  state_t state, next;
  logic   retire;
  logic   pc_write_raw, ir_write_raw, mem_read_raw;
  logic   mem_write_raw, reg_write_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FETCH;
      instr_retired <= '0;
    end else begin
      state <= next;
      if (retire)
        instr_retired <= instr_retired + 1'b1;
    end
  end

  always_comb begin
    next          = state;
    retire        = 1'b0;
    alu_opcode    = OP_LW;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_src        = 2'b00;
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    iord          = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal       = 1'b0;
    unique case (state)
      FETCH: begin
        mem_read_raw = 1'b1;
        alu_src_b    = 2'b01;
        if (mem_ready) begin
          ir_write_raw = 1'b1;
          pc_write_raw = 1'b1;
          next         = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        unique case (opcode)
          OP_R:         next = EXEC_R;
          OP_LW, OP_SW: next = MEM_ADDR;
          OP_BEQ:       next = BRANCH;
          OP_J:         next = JUMP;
          default:      next = TRAP;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        unique case (opcode)
          OP_LW:   next = MEM_RD;
          OP_SW:   next = MEM_WR;
          // opcode changed mid-instruction: refuse to guess
          default: next = TRAP;
        endcase
      end
      MEM_RD: begin
        mem_read_raw = 1'b1;
        iord         = 1'b1;
        if (mem_ready) next = WB_LOAD;
      end
      WB_LOAD: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
        retire        = 1'b1;
        next          = FETCH;
      end
      MEM_WR: begin
        mem_write_raw = 1'b1;
        iord          = 1'b1;
        if (mem_ready) begin
          retire = 1'b1;
          next   = FETCH;
        end
      end
      EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_opcode = OP_R;
        next       = WB_R;
      end
      WB_R: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
        retire        = 1'b1;
        next          = FETCH;
      end
      BRANCH: begin
        alu_src_a    = 1'b1;
        alu_opcode   = OP_BEQ;
        pc_src       = 2'b01;
        pc_write_raw = zero;
        retire       = 1'b1;
        next         = FETCH;
      end
      JUMP: begin
        pc_src       = 2'b10;
        pc_write_raw = 1'b1;
        retire       = 1'b1;
        next         = FETCH;
      end
      TRAP: begin
        illegal = 1'b1;
      end
      default: next = TRAP;
    endcase
  end

  // reset aborts whatever is in flight, so no strobe may escape this cycle
  assign pc_write  = pc_write_raw  & ~rst;
  assign ir_write  = ir_write_raw  & ~rst;
  assign mem_read  = mem_read_raw  & ~rst;
  assign mem_write = mem_write_raw & ~rst;
  assign reg_write = reg_write_raw & ~rst;
  assign state_dbg = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: expected per-cycle outputs queued at drive time,
// popped and compared by a negedge monitor.
module tb_mips_multicycle_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    opcode;
  logic          zero;
  logic          mem_ready;
  logic [5:0]    alu_opcode;
  logic          alu_src_a;
  logic [1:0]    alu_src_b;
  logic [1:0]    pc_src;
  logic          pc_write, ir_write, iord, mem_read, mem_write;
  logic          reg_write, reg_dst, mem_to_reg, illegal;
  logic [3:0]    state_dbg;
  logic [CW-1:0] instr_retired;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .alu_opcode(alu_opcode),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .pc_write(pc_write), .ir_write(ir_write),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal(illegal),
    .state_dbg(state_dbg), .instr_retired(instr_retired)
  );

  localparam logic [3:0] S_FETCH = 0, S_DEC = 1, S_MADDR = 2,
    S_MRD = 3, S_WBL = 4, S_MWR = 5, S_EXR = 6, S_WBR = 7,
    S_BR = 8, S_J = 9, S_TRAP = 10;

  typedef struct packed {
    logic [3:0]    st;
    logic [19:0]   outs;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [CW-1:0] ecnt;

  // {aop, srca, srcb, pcs, pcw, irw, iord, mrd, mwr, rw, rdst, m2r, ill}
  wire [19:0] act_outs = {alu_opcode, alu_src_a, alu_src_b, pc_src,
    pc_write, ir_write, iord, mem_read, mem_write, reg_write,
    reg_dst, mem_to_reg, illegal};

  function automatic logic [19:0] mdl(input logic [3:0] s,
      input logic z, input logic mr, input logic r);
    logic [5:0] aop;
    logic       sa, pw, iw, io, rd, wr, rw, rdst, m2r, il;
    logic [1:0] sb2, ps;
    aop = 6'h23; sa = 0; sb2 = 0; ps = 0; pw = 0; iw = 0; io = 0;
    rd = 0; wr = 0; rw = 0; rdst = 0; m2r = 0; il = 0;
    case (s)
      S_FETCH: begin rd = 1; sb2 = 2'b01; iw = mr; pw = mr; end
      S_DEC:   begin sb2 = 2'b11; end
      S_MADDR: begin sa = 1; sb2 = 2'b10; end
      S_MRD:   begin rd = 1; io = 1; end
      S_WBL:   begin rw = 1; m2r = 1; end
      S_MWR:   begin wr = 1; io = 1; end
      S_EXR:   begin sa = 1; aop = 6'h00; end
      S_WBR:   begin rw = 1; rdst = 1; end
      S_BR:    begin sa = 1; aop = 6'h04; ps = 2'b01; pw = z; end
      S_J:     begin ps = 2'b10; pw = 1; end
      S_TRAP:  begin il = 1; end
      default: ;
    endcase
    if (r) begin pw = 0; iw = 0; rd = 0; wr = 0; rw = 0; end
    return {aop, sa, sb2, ps, pw, iw, io, rd, wr, rw, rdst, m2r, il};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
      input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // inputs for this cycle are already set; queue what must be seen
  task automatic step(input logic [3:0] es);
    exp_t e;
    e.st   = es;
    e.outs = mdl(es, zero, mem_ready, rst);
    e.cnt  = ecnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("state", 32'(state_dbg), 32'(e.st));
      chk("outs", 32'(act_outs), 32'(e.outs));
      chk("count", 32'(instr_retired), 32'(e.cnt));
    end
  end

  task automatic fetch(input logic [5:0] op);
    opcode = op; mem_ready = 1;
    step(S_FETCH);
    step(S_DEC);
  endtask

  task automatic do_jump();
    fetch(6'h02);
    step(S_J);
    ecnt++;
  endtask

  initial begin
    rst = 1; opcode = 0; zero = 0; mem_ready = 0; ecnt = 0;
    @(posedge clk); #1;
    step(S_FETCH);
    rst = 0;
    step(S_FETCH);
    step(S_FETCH);

    fetch(6'h00);
    step(S_EXR);
    step(S_WBR);
    ecnt++;

    fetch(6'h23);
    step(S_MADDR);
    mem_ready = 0;
    repeat (3) step(S_MRD);
    mem_ready = 1;
    step(S_MRD);
    mem_ready = 0;
    step(S_WBL);
    ecnt++;

    zero = 1;
    fetch(6'h04);
    step(S_BR);
    ecnt++;
    zero = 0;
    fetch(6'h04);
    step(S_BR);
    ecnt++;

    fetch(6'h2B);
    step(S_MADDR);
    mem_ready = 0;
    step(S_MWR);
    mem_ready = 1;
    step(S_MWR);
    ecnt++;

    do_jump();

    fetch(6'h3F);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      step(S_TRAP);
    end
    rst = 1;
    step(S_TRAP);
    rst = 0; ecnt = 0;
    mem_ready = 0;
    step(S_FETCH);

    for (int i = 0; i < 17; i++) do_jump();
    mem_ready = 0;
    step(S_FETCH);
    chk("wrap", 32'(instr_retired), 32'd1);

    fetch(6'h2B);
    step(S_MADDR);
    rst = 1; mem_ready = 1;
    step(S_MWR);
    rst = 0; ecnt = 0; mem_ready = 0;
    step(S_FETCH);

    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
